fetch_stage: RTL and testbench

- Instruction fetch stage and IF/ID pipeline register of the 5-stage RV32I core.
- Holds the PC and issues one instruction-memory request at a time over a valid/ready request channel with a valid-only response channel.
- Delivers fetched instructions into the IF/ID register.
- Obeys the stall and flush controls from the hazard logic and the branch redirect from EX.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: a request channel plus a response channel.
// Request is valid/ready: a transfer happens on a clk edge where valid && ready; the
// response channel is valid-only and carries exactly one word per accepted request.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage and IF/ID pipeline register.
// One outstanding imem request at a time; honours stall, flush and branch redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          if_stall,
    input  logic          id_stall,
    input  logic          id_flush,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    fetch_stage_if.master imem,
    output logic          id_valid,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_pc_plus4,
    output logic [31:0]   id_instr,
    output logic [1:0]    state_dbg
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RSP  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    logic        kill;

    logic        req_fire;
    logic        rsp_take;
    logic        hold_release;
    logic        deliver;
    logic [31:0] deliver_pc;
    logic [31:0] deliver_instr;

    assign imem.imem_req_valid = rstn && (state == S_REQ) && !if_stall;
    assign imem.imem_req_addr  = pc;
    assign state_dbg           = state;

    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
    // A response is usable only if no redirect has overtaken it.
    assign rsp_take     = (state == S_RSP) && imem.imem_rsp_valid && !kill && !branch_taken;
    assign hold_release = (state == S_HOLD) && !id_stall && !id_flush && !branch_taken;
    assign deliver      = (rsp_take && !id_stall) || hold_release;

    assign deliver_pc    = (state == S_HOLD) ? held_pc    : req_pc;
    assign deliver_instr = (state == S_HOLD) ? held_instr : imem.imem_rsp_data;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            kill        <= 1'b0;
            held_pc     <= 32'd0;
            held_instr  <= NOP_INSTR;
            id_valid    <= 1'b0;
            id_pc       <= 32'd0;
            id_pc_plus4 <= 32'd4;
            id_instr    <= NOP_INSTR;
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        kill   <= branch_taken;
                        state  <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (imem.imem_rsp_valid) begin
                        kill <= 1'b0;
                        if (rsp_take && id_stall) begin
                            held_pc    <= req_pc;
                            held_instr <= imem.imem_rsp_data;
                            state      <= S_HOLD;
                        end else begin
                            state <= S_REQ;
                        end
                    end else if (branch_taken) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (branch_taken || hold_release) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            // Redirect wins over every sequential PC advance.
            if (branch_taken) begin
                pc <= {branch_target[31:2], 2'b00};
            end else if (deliver) begin
                pc <= deliver_pc + 32'd4;
            end

            if (id_flush) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end else if (id_stall) begin
                id_valid <= id_valid;
            end else if (deliver) begin
                id_valid    <= 1'b1;
                id_pc       <= deliver_pc;
                id_pc_plus4 <= deliver_pc + 32'd4;
                id_instr    <= deliver_instr;
            end else begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of per-cycle vectors for streaming and if_stall,
// hand-written sequences for hold, redirect, flush, wrap and reset corner cases.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        if_stall;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_id_valid;
        logic [31:0] exp_id_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        if_stall = 1'b0;
    logic        id_stall = 1'b0;
    logic        id_flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic [1:0]  state_dbg;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk           (clk),
        .rstn          (rstn),
        .if_stall      (if_stall),
        .id_stall      (id_stall),
        .id_flush      (id_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (bus),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .id_instr      (id_instr),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'd0;
    vec_t        tbl[11];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d deliveries outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, "_id_pc"}, id_pc, 32'd0);
        check({tag, "_id_pc_plus4"}, id_pc_plus4, 32'd4);
        check({tag, "_id_instr"}, id_instr, NOP);
        check({tag, "_req_valid"}, {31'd0, bus.imem_req_valid}, 32'd0);
        check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        if_stall = 1'b0;
        id_stall = 1'b0;
        id_flush = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        bus.imem_req_ready = 1'b0;
        repeat (5) tick();
        exp_q.delete();
        check_reset_values("reset");
        rstn = 1'b1;
    endtask

    // Memory model: samples the request at the falling edge preceding the accepting edge.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'd0;
        bus.imem_req_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.imem_rsp_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data = mem_word(pend_addr);
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend_cnt = mem_lat;
                pend_addr = bus.imem_req_addr;
            end
        end
    end

    // Scoreboard: a new IF/ID delivery is valid that was not merely held by id_stall.
    initial begin
        logic        prev_valid;
        logic        prev_stall;
        logic [63:0] e;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && id_valid && !(prev_valid && prev_stall)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got pc %h, expected no delivery", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_pc", id_pc, e[63:32]);
                    check("deliver_instr", id_instr, e[31:0]);
                    check("deliver_pc_plus4", id_pc_plus4, e[63:32] + 32'd4);
                end
            end
            prev_valid = id_valid;
            prev_stall = id_stall;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming with 1-cycle memory, then if_stall with ready held high.
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
        tbl[3]  = '{1'b0, 1'b0, 32'h04, 1'b0, 32'h00};
        tbl[4]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
        tbl[5]  = '{1'b0, 1'b0, 32'h08, 1'b0, 32'h04};
        tbl[6]  = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h08};
        tbl[7]  = '{1'b1, 1'b0, 32'h0C, 1'b0, 32'h08};
        tbl[8]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 32'h08};
        tbl[9]  = '{1'b0, 1'b0, 32'h0C, 1'b0, 32'h08};
        tbl[10] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};

        do_reset();
        mem_lat = 1;
        bus.imem_req_ready = 1'b1;
        expect_fetch(32'h00);
        expect_fetch(32'h04);
        expect_fetch(32'h08);
        expect_fetch(32'h0C);
        for (int i = 0; i < 11; i++) begin
            if_stall = tbl[i].if_stall;
            #1;
            check($sformatf("vec%0d_req_valid", i), {31'd0, bus.imem_req_valid}, {31'd0, tbl[i].exp_req_valid});
            check($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, tbl[i].exp_req_addr);
            check($sformatf("vec%0d_id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].exp_id_valid});
            check($sformatf("vec%0d_id_pc", i), id_pc, tbl[i].exp_id_pc);
            tick();
        end
        if_stall = 1'b0;
        wait_drain("stream_drain", 20);

        // Response for pc=8 lands while id_stall is high for three edges.
        do_reset();
        mem_lat = 1;
        bus.imem_req_ready = 1'b1;
        expect_fetch(32'h00);
        expect_fetch(32'h04);
        expect_fetch(32'h08);
        expect_fetch(32'h0C);
        repeat (5) tick();
        id_stall = 1'b1;
        tick();
        check("hold_state", {30'd0, state_dbg}, 32'd2);
        check("hold_id_pc", id_pc, 32'h04);
        check("hold_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        repeat (2) tick();
        check("hold_state_late", {30'd0, state_dbg}, 32'd2);
        check("hold_id_pc_late", id_pc, 32'h04);
        id_stall = 1'b0;
        tick();
        check("release_id_valid", {31'd0, id_valid}, 32'd1);
        check("release_id_pc", id_pc, 32'h08);
        check("release_req_addr", bus.imem_req_addr, 32'h0C);
        check("release_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        wait_drain("hold_drain", 20);

        // Redirect to 0x100 while waiting on the response for 0x20.
        do_reset();
        mem_lat = 3;
        branch_taken = 1'b1;
        branch_target = 32'h20;
        tick();
        branch_taken = 1'b0;
        bus.imem_req_ready = 1'b1;
        #1;
        check("redir_first_addr", bus.imem_req_addr, 32'h20);
        check("redir_first_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        tick();
        check("redir_in_rsp", {30'd0, state_dbg}, 32'd1);
        branch_taken = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        check("redir_still_rsp", {30'd0, state_dbg}, 32'd1);
        check("redir_pc_updated", bus.imem_req_addr, 32'h100);
        check("redir_no_req_in_rsp", {31'd0, bus.imem_req_valid}, 32'd0);
        repeat (2) tick();
        check("redir_back_to_req", {30'd0, state_dbg}, 32'd0);
        check("redir_next_addr", bus.imem_req_addr, 32'h100);
        check("redir_id_invalid", {31'd0, id_valid}, 32'd0);
        expect_fetch(32'h100);
        wait_drain("redir_drain", 30);

        // Misaligned redirect coincident with a handshake, together with id_flush.
        do_reset();
        mem_lat = 1;
        bus.imem_req_ready = 1'b1;
        expect_fetch(32'h00);
        repeat (2) tick();
        check("flush_pre_id_valid", {31'd0, id_valid}, 32'd1);
        check("flush_pre_handshake", {31'd0, bus.imem_req_valid}, 32'd1);
        branch_taken = 1'b1;
        branch_target = 32'h203;
        id_flush = 1'b1;
        tick();
        branch_taken = 1'b0;
        id_flush = 1'b0;
        check("flush_id_valid", {31'd0, id_valid}, 32'd0);
        check("flush_id_instr", id_instr, NOP);
        check("flush_state_rsp", {30'd0, state_dbg}, 32'd1);
        tick();
        check("flush_state_req", {30'd0, state_dbg}, 32'd0);
        check("flush_next_addr", bus.imem_req_addr, 32'h200);
        expect_fetch(32'h200);
        wait_drain("flush_drain", 20);

        // PC wraps from 0xFFFF_FFFC to 0.
        do_reset();
        mem_lat = 1;
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        tick();
        branch_taken = 1'b0;
        bus.imem_req_ready = 1'b1;
        check("wrap_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        expect_fetch(32'hFFFF_FFFC);
        wait_drain("wrap_drain", 20);
        check("wrap_next_addr", bus.imem_req_addr, 32'h0);
        check("wrap_pc_plus4", id_pc_plus4, 32'h0);

        // Reset while in S_RSP, then a stale response arrives in S_REQ.
        do_reset();
        mem_lat = 3;
        bus.imem_req_ready = 1'b1;
        tick();
        check("stale_in_rsp", {30'd0, state_dbg}, 32'd1);
        rstn = 1'b0;
        bus.imem_req_ready = 1'b0;
        tick();
        check_reset_values("midreset");
        rstn = 1'b1;
        repeat (2) tick();
        check("stale_state", {30'd0, state_dbg}, 32'd0);
        check("stale_id_valid", {31'd0, id_valid}, 32'd0);
        check("stale_req_addr", bus.imem_req_addr, 32'h0);
        check("stale_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        bus.imem_req_ready = 1'b1;
        expect_fetch(32'h0);
        wait_drain("stale_drain", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
